// File: rtl/fifo_byte_serializer.sv
// rtl/fifo_byte_serializer.sv - drains 32-bit FIFO words into a valid/ready byte stream
// One bubble cycle (WAIT) per word absorbs the FIFO's one-cycle read latency.
module fifo_byte_serializer #(
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             EMPTY,
  input  logic [31:0]      fifoData,
  output logic             RD,
  output logic [7:0]       byteOut,
  output logic             byteValid,
  input  logic             byteReady,
  output logic             busy,
  output logic [CNT_W-1:0] wordCount
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_SEND = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        hold_q, hold_d;
  logic [1:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               rd_d;
  logic               valid_d;
  logic [7:0]         out_d;
  logic [1:0]         lane;
  logic [7:0]         lane_byte;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_IDLE;
      hold_q  <= 32'h0;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Byte index counts transmission order; lane maps it onto the word.
  always_comb begin
    lane = MSB_FIRST ? (2'd3 - idx_q) : idx_q;
    case (lane)
      2'd0:    lane_byte = hold_q[7:0];
      2'd1:    lane_byte = hold_q[15:8];
      2'd2:    lane_byte = hold_q[23:16];
      default: lane_byte = hold_q[31:24];
    endcase
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rd_d    = 1'b0;
    valid_d = 1'b0;
    out_d   = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (!EMPTY) begin
          rd_d    = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        hold_d  = fifoData;
        idx_d   = 2'd0;
        state_d = S_SEND;
      end
      S_SEND: begin
        valid_d = 1'b1;
        out_d   = lane_byte;
        if (byteReady) begin
          if (idx_q == 2'd3) begin
            cnt_d = cnt_q + CNT_W'(1);
            idx_d = 2'd0;
            // Chain straight into the next word to keep the single-bubble cadence.
            if (!EMPTY) begin
              rd_d    = 1'b1;
              state_d = S_WAIT;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // RD is combinational from EMPTY, so it must be masked while reset is held.
  assign RD        = rd_d & ~Rst;
  assign byteValid = valid_d;
  assign byteOut   = out_d;
  assign busy      = (state_q != S_IDLE);
  assign wordCount = cnt_q;

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// tb/tb_fifo_byte_serializer.sv - bench for fifo_byte_serializer in both byte orders
module tb_fifo_byte_serializer;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        EMPTY = 1'b1;
  logic        byteReady = 1'b1;
  logic [31:0] fifoData = 32'h0;

  logic        rd_m, valid_m, busy_m;
  logic        rd_l, valid_l, busy_l;
  logic [7:0]  byte_m, byte_l;
  logic [15:0] cnt_m;
  logic [1:0]  cnt_l;

  always #5 Clk = ~Clk;

  fifo_byte_serializer #(.MSB_FIRST(1'b1), .CNT_W(16)) u_msb (
    .Clk(Clk), .Rst(Rst), .EMPTY(EMPTY), .fifoData(fifoData),
    .RD(rd_m), .byteOut(byte_m), .byteValid(valid_m), .byteReady(byteReady),
    .busy(busy_m), .wordCount(cnt_m)
  );

  fifo_byte_serializer #(.MSB_FIRST(1'b0), .CNT_W(2)) u_lsb (
    .Clk(Clk), .Rst(Rst), .EMPTY(EMPTY), .fifoData(fifoData),
    .RD(rd_l), .byteOut(byte_l), .byteValid(valid_l), .byteReady(byteReady),
    .busy(busy_l), .wordCount(cnt_l)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] fifo_q[$];
  logic [31:0] exp_words[$];
  logic        pop_pending = 1'b0;

  logic [7:0]  got_m[$], got_l[$];
  logic [7:0]  exp_bm[$], exp_bl[$];
  int          rd_cnt = 0;
  int          bubbles = 0;

  int          m_mode = 0;
  int          m_sent = 0;
  int unsigned m_count = 0;
  logic [31:0] m_word = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // FIFO model: a pop requested by RD at a rising edge shows up on fifoData before the next edge.
  always @(posedge Clk) begin
    if (rd_m) pop_pending = 1'b1;
  end

  always @(negedge Clk) begin
    if (pop_pending) begin
      if (fifo_q.size() > 0) fifoData = fifo_q.pop_front();
      pop_pending = 1'b0;
    end
    EMPTY = (fifo_q.size() == 0);
  end

  // Reference model: mode 0 idle, 1 fetching, 2 sending; m_sent = bytes accepted so far.
  initial begin
    logic       e_rd, e_valid, e_busy;
    logic [7:0] e_bm, e_bl;
    forever begin
      @(negedge Clk);
      #3;
      if (Rst) begin
        m_mode  = 0;
        m_sent  = 0;
        m_count = 0;
      end
      e_busy  = (m_mode != 0);
      e_valid = (m_mode == 2);
      e_bm    = e_valid ? 8'(m_word >> (8 * (3 - m_sent))) : 8'h00;
      e_bl    = e_valid ? 8'(m_word >> (8 * m_sent)) : 8'h00;
      e_rd    = !Rst && !EMPTY && ((m_mode == 0) || (m_mode == 2 && byteReady && m_sent == 3));
      chk("rd_msb", {31'h0, rd_m}, {31'h0, e_rd});
      chk("rd_lsb", {31'h0, rd_l}, {31'h0, e_rd});
      chk("valid_msb", {31'h0, valid_m}, {31'h0, e_valid});
      chk("valid_lsb", {31'h0, valid_l}, {31'h0, e_valid});
      chk("busy_msb", {31'h0, busy_m}, {31'h0, e_busy});
      chk("busy_lsb", {31'h0, busy_l}, {31'h0, e_busy});
      chk("byte_msb", {24'h0, byte_m}, {24'h0, e_bm});
      chk("byte_lsb", {24'h0, byte_l}, {24'h0, e_bl});
      chk("count_msb", {16'h0, cnt_m}, {16'h0, m_count[15:0]});
      chk("count_lsb", {30'h0, cnt_l}, {30'h0, m_count[1:0]});
      if (valid_m && byteReady) got_m.push_back(byte_m);
      if (valid_l && byteReady) got_l.push_back(byte_l);
      if (rd_m) rd_cnt++;
      if (busy_m && !valid_m) bubbles++;
      if (!Rst) begin
        case (m_mode)
          0: if (!EMPTY) m_mode = 1;
          1: begin
            if (exp_words.size() > 0) m_word = exp_words.pop_front();
            m_sent = 0;
            m_mode = 2;
          end
          default: begin
            if (byteReady) begin
              m_sent++;
              if (m_sent == 4) begin
                m_count++;
                m_mode = EMPTY ? 0 : 1;
              end
            end
          end
        endcase
      end
    end
  end

  task automatic push_word(input logic [31:0] w);
    fifo_q.push_back(w);
    exp_words.push_back(w);
  endtask

  task automatic clear_obs();
    got_m.delete();
    got_l.delete();
    rd_cnt  = 0;
    bubbles = 0;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge Clk);
      if (got_m.size() >= n) done = 1'b1;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_bytes: got %0d bytes, required %0d", got_m.size(), n);
    end
  endtask

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge Clk);
      #4;
      if (!busy_m && EMPTY && fifo_q.size() == 0) done = 1'b1;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_idle: busy %0b, fifo depth %0d, required idle", busy_m, fifo_q.size());
    end
  endtask

  task automatic check_seqs(input string nm);
    chk({nm, "_len_msb"}, got_m.size(), exp_bm.size());
    chk({nm, "_len_lsb"}, got_l.size(), exp_bl.size());
    for (int i = 0; i < exp_bm.size() && i < got_m.size(); i++)
      chk($sformatf("%s_msb_b%0d", nm, i), {24'h0, got_m[i]}, {24'h0, exp_bm[i]});
    for (int i = 0; i < exp_bl.size() && i < got_l.size(); i++)
      chk($sformatf("%s_lsb_b%0d", nm, i), {24'h0, got_l[i]}, {24'h0, exp_bl[i]});
  endtask

  initial begin
    #500000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    // Reset and empty idle
    Rst = 1'b1;
    byteReady = 1'b1;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    repeat (10) @(negedge Clk);
    chk("idle_rd_pulses", rd_cnt, 0);
    chk("idle_bytes", got_m.size(), 0);
    chk("idle_count", {16'h0, cnt_m}, 32'd0);

    // Single word in both byte orders
    @(negedge Clk);
    clear_obs();
    push_word(32'h11223344);
    wait_bytes(4, 40);
    wait_idle(40);
    exp_bm = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_bl = '{8'h44, 8'h33, 8'h22, 8'h11};
    check_seqs("single");
    chk("single_rd_pulses", rd_cnt, 1);
    chk("single_bubbles", bubbles, 1);
    chk("single_count_msb", {16'h0, cnt_m}, 32'd1);
    chk("single_count_lsb", {30'h0, cnt_l}, 32'd1);

    // Backpressure at byte index 1
    @(negedge Clk);
    clear_obs();
    push_word(32'hA1B2C3D4);
    wait_bytes(1, 40);
    byteReady = 1'b0;
    repeat (3) begin
      #2;
      chk("stall_byte_msb", {24'h0, byte_m}, 32'hB2);
      chk("stall_byte_lsb", {24'h0, byte_l}, 32'hC3);
      chk("stall_valid", {31'h0, valid_m}, 32'd1);
      @(negedge Clk);
    end
    byteReady = 1'b1;
    wait_bytes(4, 40);
    wait_idle(40);
    exp_bm = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    exp_bl = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    check_seqs("stall");
    chk("stall_rd_pulses", rd_cnt, 1);
    chk("stall_count_msb", {16'h0, cnt_m}, 32'd2);

    // Back-to-back words 1..5; 2-bit counter wraps 7 -> 3
    @(negedge Clk);
    clear_obs();
    exp_bm.delete();
    exp_bl.delete();
    for (int k = 1; k <= 5; k++) begin
      push_word(32'(k));
      exp_bm.push_back(8'h00); exp_bm.push_back(8'h00);
      exp_bm.push_back(8'h00); exp_bm.push_back(8'(k));
      exp_bl.push_back(8'(k)); exp_bl.push_back(8'h00);
      exp_bl.push_back(8'h00); exp_bl.push_back(8'h00);
    end
    wait_bytes(20, 200);
    wait_idle(40);
    check_seqs("b2b");
    chk("b2b_rd_pulses", rd_cnt, 5);
    chk("b2b_bubbles", bubbles, 5);
    chk("b2b_count_msb", {16'h0, cnt_m}, 32'd7);
    chk("b2b_count_wrap_lsb", {30'h0, cnt_l}, 32'd3);

    // Asynchronous reset after the second byte
    @(negedge Clk);
    clear_obs();
    push_word(32'hDEADBEEF);
    wait_bytes(2, 40);
    #1 Rst = 1'b1;
    #1;
    chk("rst_rd", {31'h0, rd_m}, 32'd0);
    chk("rst_valid", {31'h0, valid_m}, 32'd0);
    chk("rst_byte", {24'h0, byte_m}, 32'd0);
    chk("rst_busy", {31'h0, busy_m}, 32'd0);
    chk("rst_count_msb", {16'h0, cnt_m}, 32'd0);
    chk("rst_count_lsb", {30'h0, cnt_l}, 32'd0);
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    clear_obs();
    repeat (10) @(negedge Clk);
    chk("post_rst_bytes", got_m.size(), 0);
    chk("post_rst_rd_pulses", rd_cnt, 0);
    chk("post_rst_count", {16'h0, cnt_m}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
